// File: rtl/ecc_enc_fifo.sv
// ecc_enc_fifo: encodes 16-bit data words into 34-bit codewords (18 check bits),
// registers them in an encode stage and buffers them in a DEPTH-entry FIFO.
module ecc_enc_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            in_data,
    input  logic [33:0]            inj_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [33:0]            out_cw,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [15:0]            inj_count
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t DEPTH_C = ptr_t'(DEPTH);

    // Check bits in codeword order [33:16]; layout is fixed by the decoder downstream.
    function automatic logic [17:0] check_bits(input logic [15:0] x);
        logic [17:0] c;
        c[0]  = x[0] ^ x[2];
        c[1]  = x[1] ^ x[3];
        c[2]  = x[3] ^ x[7] ^ x[11] ^ x[15];
        c[3]  = x[3] ^ x[6] ^ x[11] ^ x[14];
        c[4]  = x[4] ^ x[6];
        c[5]  = x[5] ^ x[7];
        c[6]  = x[2] ^ x[6] ^ x[10] ^ x[14];
        c[7]  = x[2] ^ x[7] ^ x[10] ^ x[15];
        c[8]  = x[8] ^ x[10];
        c[9]  = x[9] ^ x[11];
        c[10] = x[1] ^ x[5] ^ x[9]  ^ x[13];
        c[11] = x[1] ^ x[4] ^ x[9]  ^ x[12];
        c[12] = x[12] ^ x[14];
        c[13] = x[13] ^ x[15];
        c[14] = x[0] ^ x[4] ^ x[8]  ^ x[12];
        c[15] = x[0] ^ x[5] ^ x[8]  ^ x[13];
        c[16] = x[2] ^ x[5] ^ x[10] ^ x[13];
        c[17] = x[1] ^ x[6] ^ x[9]  ^ x[14];
        return c;
    endfunction

    logic        accept;
    logic        pop;
    logic        e_valid;
    logic [33:0] e_cw;
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    ptr_t        occ_q;
    ptr_t        occ_next;
    logic [33:0] mem [DEPTH];

    // Ready depends only on registered occupancy, so a pop never feeds in_ready in the same cycle.
    assign in_ready  = !rst && (occ_q < DEPTH_C);
    assign accept    = in_valid && in_ready;
    assign out_valid = (wr_ptr != rd_ptr);
    assign pop       = out_valid && out_ready;
    assign out_cw    = mem[rd_ptr[AW-1:0]];
    assign occupancy = occ_q;

    always_comb begin
        // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
        occ_next = occ_q;
        if (accept && !pop)
            occ_next = occ_q + ptr_t'(1);
        else if (!accept && pop)
            occ_next = occ_q - ptr_t'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid   <= 1'b0;
            e_cw      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ_q     <= '0;
            inj_count <= '0;
        end else begin
            e_valid <= accept;
            if (accept) begin
                e_cw <= {check_bits(in_data), in_data} ^ inj_mask;
                if ((inj_mask != '0) && (inj_count != 16'hFFFF))
                    inj_count <= inj_count + 16'd1;
            end
            // The credit check on occupancy guarantees a free slot for the encode stage.
            if (e_valid)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)
                rd_ptr <= rd_ptr + ptr_t'(1);
            occ_q <= occ_next;
        end
    end

    // NOTE: the storage array is not reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && e_valid)
            mem[wr_ptr[AW-1:0]] <= e_cw;
    end

endmodule

// File: doc/ecc_enc_fifo.md
# ecc_enc_fifo

Write-side front end of the 16-bit space-data ECC path. Accepts 16-bit data words over a valid/ready handshake and computes the 18 check bits (6 diagonal, 4 column parity, 8 group check bits). It buffers the resulting 34-bit codewords in a DEPTH-entry FIFO and presents them over a valid/ready handshake to the codeword decoder/corrector downstream. An XOR fault-injection mask lets the bench and in-flight self-test corrupt stored codewords deliberately.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  data word offered
- in_ready  out  1  block can accept; forced 0 while rst=1
- in_data  in  16  data word X[15:0]
- inj_mask  in  34  XOR mask applied to the codeword of the accepted word; sampled with in_data
- out_valid  out  1  head codeword available
- out_ready  in  1  downstream consumes head
- out_cw  out  34  head codeword; {check[33:16], X[15:0]}
- occupancy  out  $clog2(DEPTH)+1  words held (encode stage + FIFO)
- inj_count  out  16  accepted words with nonzero inj_mask, saturating at 16'hFFFF

## Operation
- Codeword layout, all XORs of X bits:
  - [15:0]=X
  - 16=X0^X2, 17=X1^X3, 18 P1=X3^X7^X11^X15, 19 D1=X3^X6^X11^X14
  - 20=X4^X6, 21=X5^X7, 22 P2=X2^X6^X10^X14, 23 D2=X2^X7^X10^X15
  - 24=X8^X10, 25=X9^X11, 26 P3=X1^X5^X9^X13, 27 D3=X1^X4^X9^X12
  - 28=X12^X14, 29=X13^X15, 30 P4=X0^X4^X8^X12, 31 D4=X0^X5^X8^X13
  - 32 D5=X2^X5^X10^X13, 33 D6=X1^X6^X9^X14
- Pipeline: stage E (encode register, 34b + valid) feeds a circular FIFO (DEPTH×34 storage, wr/rd pointers of width $clog2(DEPTH)+1, wrap via MSB).
- Accept: in_valid&in_ready. E captures encode(in_data)^inj_mask.
- E drains into FIFO on the next edge unconditionally. Credit rule guarantees space.
- in_ready = !rst && (occupancy < DEPTH); occupancy counts E plus FIFO entries.
- Pop: out_valid&out_ready advances rd pointer. out_cw = storage[rd] (registered storage, no bypass from E).
- Push and pop in the same cycle: both occur; occupancy changes by (accept − pop).
- out_cw is don't-care when out_valid=0, but must hold stable while out_valid=1 and out_ready=0.
- inj_count increments on accept when inj_mask≠0; stops at FFFF.

## Timing
- Reset (rst high at an edge): pointers, E valid, occupancy, inj_count ← 0; out_valid=0; in_ready=0 during rst, 1 the cycle after.
- Reset mid-operation discards all buffered words; no partial output.
- Latency: word accepted at edge N → written at edge N+1 → out_valid=1 in cycle after N+1 (2 cycles) if FIFO was empty.
- Throughput: one word per cycle sustained with out_ready=1.
- Full: occupancy=DEPTH → in_ready=0 combinationally in the same cycle. A pop in that cycle does not raise in_ready until the next cycle (no ready-from-ready path).
- Empty: out_valid=0; out_ready ignored; no pointer movement.
- Pointer wrap: wr/rd index bits wrap modulo DEPTH; full/empty decided from the MSB.

## Test plan
- Reset then in_data=16'h0001, inj_mask=0, out_ready=1 → out_cw=34'h0_C001_0001 exactly 2 cycles after accept; inj_count=0.
- in_data=16'hFFFF → 34'h0_0000_FFFF; in_data=16'h8000 → 34'h0_2084_8000.
- out_ready=0, push DEPTH+3 words back-to-back → in_ready drops after DEPTH accepts, occupancy=DEPTH. Release out_ready → the DEPTH words emerge in order, nothing lost or duplicated; pointers wrap twice across two such rounds.
- inj_mask=34'h0_0000_0001 with in_data=16'h0001 → out_cw=34'h0_C001_0000; inj_count=1. 70000 injected accepts → inj_count=16'hFFFF.
- Random valid/ready throttling, 10k words, against a reference encoder plus queue model → bit-exact codewords and order; out_cw stable under backpressure.
- Assert rst with 5 words buffered → next cycle out_valid=0, occupancy=0, in_ready=0. Following cycle in_ready=1, and the first new word emerges with 2-cycle latency.
